in_flit_dispatch: RTL and testbench



---
 rtl/in_flit_dispatch.sv | 163 ++++++++++++++++
 tb/tb_in_flit_dispatch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/in_flit_dispatch.sv
// Purpose : steers whole messages from the request/reply IN fifos to the
//           mem/ic/dc download stages, with round-robin arbitration per message.
// Ports   : req_*/rep_* fifo heads and pops; *_download_state target idle status;
//           flit_out/ctrl_out plus one v_flit_* strobe per target; seq_err drop pulse.
// Latency : zero; a flit is popped and presented to its target in the same cycle.
// Backpressure: none toward targets; a new message waits for its target to be idle.
module in_flit_dispatch #(
  parameter int                         CMD_MSB     = 9,
  parameter int                         CMD_LSB     = 5,
  parameter logic [CMD_MSB-CMD_LSB:0]   INSTREP_CMD = 5'b10100,
  parameter logic [1:0]                 DL_IDLE     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_flit,
  input  logic [1:0]  req_ctrl,
  input  logic        v_req,
  output logic        req_pop,
  input  logic [15:0] rep_flit,
  input  logic [1:0]  rep_ctrl,
  input  logic        v_rep,
  output logic        rep_pop,
  input  logic [1:0]  mem_download_state,
  input  logic [1:0]  ic_download_state,
  input  logic [1:0]  dc_download_state,
  output logic [15:0] flit_out,
  output logic [1:0]  ctrl_out,
  output logic        v_flit_mem,
  output logic        v_flit_ic,
  output logic        v_flit_dc,
  output logic        seq_err
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  localparam logic [1:0] TGT_MEM   = 2'd0;
  localparam logic [1:0] TGT_IC    = 2'd1;
  localparam logic [1:0] TGT_DC    = 2'd2;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  // Source encoding: 0 = request fifo, 1 = reply fifo.
  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       lock_src_q, lock_src_d;
  logic [1:0] lock_tgt_q, lock_tgt_d;

  logic [CMD_MSB-CMD_LSB:0] rep_cmd;
  logic [1:0] rep_tgt;
  logic       rep_tgt_idle;
  logic       req_is_head, rep_is_head;
  logic       req_elig, rep_elig;
  logic       grant_req, grant_rep;
  logic       req_bad, rep_bad;
  logic       lock_vld;
  logic [1:0] lock_ctrl;

  logic       pop_req, pop_rep;
  logic       fwd_vld, fwd_src;
  logic [1:0] fwd_tgt;
  logic       drop_err;

  // Head decode: request messages always go to memory; replies split on command.
  assign rep_cmd      = rep_flit[CMD_MSB:CMD_LSB];
  assign rep_tgt      = (rep_cmd == INSTREP_CMD) ? TGT_IC : TGT_DC;
  assign rep_tgt_idle = (rep_tgt == TGT_IC) ? (ic_download_state == DL_IDLE)
                                            : (dc_download_state == DL_IDLE);
  assign req_is_head  = (req_ctrl == CTRL_HEAD) || (req_ctrl == CTRL_TAIL);
  assign rep_is_head  = (rep_ctrl == CTRL_HEAD) || (rep_ctrl == CTRL_TAIL);

  assign req_elig = v_req && req_is_head && (mem_download_state == DL_IDLE);
  assign rep_elig = v_rep && rep_is_head && rep_tgt_idle;

  // prio only breaks ties; an ineligible preferred source never blocks the other.
  assign grant_req = req_elig && (!rep_elig || !prio_q);
  assign grant_rep = rep_elig && !grant_req;

  // A fifo head that is not a head flit while idle is a stray from a broken message.
  assign req_bad = v_req && !req_is_head;
  assign rep_bad = v_rep && !rep_is_head;

  assign lock_vld  = lock_src_q ? v_rep : v_req;
  assign lock_ctrl = lock_src_q ? rep_ctrl : req_ctrl;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_src_d = lock_src_q;
    lock_tgt_d = lock_tgt_q;
    pop_req    = 1'b0;
    pop_rep    = 1'b0;
    fwd_vld    = 1'b0;
    fwd_src    = 1'b0;
    fwd_tgt    = TGT_MEM;
    drop_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_req || grant_rep) begin
          fwd_vld = 1'b1;
          fwd_src = grant_rep;
          fwd_tgt = grant_rep ? rep_tgt : TGT_MEM;
          pop_req = grant_req;
          pop_rep = grant_rep;
          // Next tie goes to the source that was not just served.
          prio_d  = ~grant_rep;
          if ((grant_rep ? rep_ctrl : req_ctrl) != CTRL_TAIL) begin
            state_d    = ST_LOCK;
            lock_src_d = grant_rep;
            lock_tgt_d = grant_rep ? rep_tgt : TGT_MEM;
          end
        end else if (req_bad) begin
          pop_req  = 1'b1;
          drop_err = 1'b1;
        end else if (rep_bad) begin
          pop_rep  = 1'b1;
          drop_err = 1'b1;
        end
      end

      ST_LOCK: begin
        // Target stays busy until the tail, so its state is not rechecked here.
        fwd_src = lock_src_q;
        fwd_tgt = lock_tgt_q;
        if (lock_vld) begin
          fwd_vld = 1'b1;
          pop_req = !lock_src_q;
          pop_rep = lock_src_q;
          if (lock_ctrl == CTRL_TAIL) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      lock_src_q <= 1'b0;
      lock_tgt_q <= TGT_MEM;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_src_q <= lock_src_d;
      lock_tgt_q <= lock_tgt_d;
    end
  end

  // Everything is forced quiet while reset is held.
  assign req_pop    = !rst && pop_req;
  assign rep_pop    = !rst && pop_rep;
  assign seq_err    = !rst && drop_err;
  assign v_flit_mem = !rst && fwd_vld && (fwd_tgt == TGT_MEM);
  assign v_flit_ic  = !rst && fwd_vld && (fwd_tgt == TGT_IC);
  assign v_flit_dc  = !rst && fwd_vld && (fwd_tgt == TGT_DC);
  assign flit_out   = (!rst && fwd_vld) ? (fwd_src ? rep_flit : req_flit) : 16'h0000;
  assign ctrl_out   = (!rst && fwd_vld) ? (fwd_src ? rep_ctrl : req_ctrl) : 2'b00;

endmodule

// File: tb/tb_in_flit_dispatch.sv
// Directed bench for in_flit_dispatch: single-flit and long messages, pauses,
// arbitration and blocking, stray-flit drops, and reset in the middle of a message.
module tb_in_flit_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_flit, rep_flit;
  logic [1:0]  req_ctrl, rep_ctrl;
  logic        v_req, v_rep;
  logic        req_pop, rep_pop;
  logic [1:0]  mem_download_state, ic_download_state, dc_download_state;
  logic [15:0] flit_out;
  logic [1:0]  ctrl_out;
  logic        v_flit_mem, v_flit_ic, v_flit_dc, seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  in_flit_dispatch dut (
    .clk(clk), .rst(rst),
    .req_flit(req_flit), .req_ctrl(req_ctrl), .v_req(v_req), .req_pop(req_pop),
    .rep_flit(rep_flit), .rep_ctrl(rep_ctrl), .v_rep(v_rep), .rep_pop(rep_pop),
    .mem_download_state(mem_download_state),
    .ic_download_state(ic_download_state),
    .dc_download_state(dc_download_state),
    .flit_out(flit_out), .ctrl_out(ctrl_out),
    .v_flit_mem(v_flit_mem), .v_flit_ic(v_flit_ic), .v_flit_dc(v_flit_dc),
    .seq_err(seq_err)
  );

  // {req_pop, rep_pop, v_mem, v_ic, v_dc, seq_err, ctrl_out, flit_out}
  logic [23:0] obs;
  assign obs = {req_pop, rep_pop, v_flit_mem, v_flit_ic, v_flit_dc, seq_err, ctrl_out, flit_out};

  localparam logic [23:0] Z = 24'h0;

  function automatic logic [23:0] ex(input logic rp, input logic pp, input logic m,
                                     input logic i, input logic d, input logic s,
                                     input logic [1:0] c, input logic [15:0] f);
    return {rp, pp, m, i, d, s, c, f};
  endfunction

  // Flit with the command in bits 9:5.
  function automatic logic [15:0] hf(input logic [4:0] cmd, input logic [4:0] lo);
    return {6'b101100, cmd, lo};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Compare at the falling edge, then advance past the next rising edge.
  // With care=0 only the strobes are compared (data bus value is irrelevant).
  task automatic step(input string tag, input logic [23:0] want, input logic care);
    @(negedge clk);
    if (care) check(tag, obs, want);
    else      check(tag, {obs[23:18], 18'h0}, {want[23:18], 18'h0});
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic vq, input logic [1:0] cq, input logic [15:0] fq,
                     input logic vp, input logic [1:0] cp, input logic [15:0] fp);
    v_req = vq; req_ctrl = cq; req_flit = fq;
    v_rep = vp; rep_ctrl = cp; rep_flit = fp;
  endtask

  logic [15:0] nack, rq, rp, f, r0, r1, r2, rp2, rq2, rq3, ins, rpx;
  logic [1:0]  c;

  initial begin
    rst = 1'b1;
    mem_download_state = 2'b00;
    ic_download_state  = 2'b00;
    dc_download_state  = 2'b00;
    drv(1'b1, 2'b11, hf(5'd3, 5'd1), 1'b1, 2'b11, hf(5'b10101, 5'd1));
    @(posedge clk); #1;
    // Valid heads present while reset is held: everything must stay quiet.
    step("rst_quiet", Z, 1'b1);
    rst = 1'b0;

    // Single-flit nackrep to dc.
    nack = hf(5'b10101, 5'd2);
    drv(1'b0, 2'b00, 16'h0, 1'b1, 2'b11, nack);
    step("nack", ex(0,1,0,0,1,0,2'b11,nack), 1'b1);
    drv(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    step("nack_after", Z, 1'b0);

    // prio is 0 after the reply grant: request wins the tie, then reply.
    rq = hf(5'd3, 5'd3);
    rp = hf(5'b00001, 5'd3);
    drv(1'b1, 2'b11, rq, 1'b1, 2'b11, rp);
    step("tie_req_first", ex(1,0,1,0,0,0,2'b11,rq), 1'b1);
    step("tie_rep_next", ex(0,1,0,0,1,0,2'b11,rp), 1'b1);

    // 9-flit shrep with a 2-cycle gap; a request head waits behind a busy mem
    // and must not be popped while the reply message is locked.
    mem_download_state = 2'b01;
    for (int k = 0; k < 9; k++) begin
      f = hf(5'b00001, k[4:0] + 5'd4);
      c = (k == 0) ? 2'b01 : ((k == 8) ? 2'b11 : 2'b10);
      if (k == 3) begin
        drv(1'b1, 2'b11, rq, 1'b0, 2'b10, f);
        step("shrep_gap0", Z, 1'b0);
        step("shrep_gap1", Z, 1'b0);
      end
      drv(1'b1, 2'b11, rq, 1'b1, c, f);
      step($sformatf("shrep_%0d", k), ex(0,1,0,0,1,0,c,f), 1'b1);
      if (k == 0) dc_download_state = 2'b01;
    end
    dc_download_state  = 2'b00;
    mem_download_state = 2'b00;

    // Back-to-back: 3-flit request first (prio 0), reply head right after the tail.
    r0  = hf(5'd3, 5'd20);
    r1  = hf(5'd3, 5'd21);
    r2  = hf(5'd3, 5'd22);
    rp2 = hf(5'b00110, 5'd23);
    drv(1'b1, 2'b01, r0, 1'b1, 2'b11, rp2);
    step("b2b_req_head", ex(1,0,1,0,0,0,2'b01,r0), 1'b1);
    drv(1'b1, 2'b10, r1, 1'b1, 2'b11, rp2);
    step("b2b_req_body", ex(1,0,1,0,0,0,2'b10,r1), 1'b1);
    drv(1'b1, 2'b11, r2, 1'b1, 2'b11, rp2);
    step("b2b_req_tail", ex(1,0,1,0,0,0,2'b11,r2), 1'b1);
    drv(1'b0, 2'b00, 16'h0, 1'b1, 2'b11, rp2);
    step("b2b_rep_head", ex(0,1,0,0,1,0,2'b11,rp2), 1'b1);

    // Make reply preferred, then block it on a busy ic: request still goes.
    rq2 = hf(5'd3, 5'd24);
    drv(1'b1, 2'b11, rq2, 1'b0, 2'b00, 16'h0);
    step("single_req", ex(1,0,1,0,0,0,2'b11,rq2), 1'b1);
    ic_download_state = 2'b10;
    rq3 = hf(5'd3, 5'd25);
    ins = hf(5'b10100, 5'd26);
    drv(1'b1, 2'b11, rq3, 1'b1, 2'b11, ins);
    step("ic_busy_req_wins", ex(1,0,1,0,0,0,2'b11,rq3), 1'b1);
    drv(1'b0, 2'b00, 16'h0, 1'b1, 2'b11, ins);
    step("instrep_held", Z, 1'b0);
    ic_download_state = 2'b00;
    step("instrep_go", ex(0,1,0,1,0,0,2'b11,ins), 1'b1);

    // Stray flits in IDLE are dropped with a one-cycle seq_err.
    drv(1'b0, 2'b00, 16'h0, 1'b1, 2'b10, hf(5'd1, 5'd27));
    step("rep_body_drop", ex(0,1,0,0,0,1,2'b00,16'h0), 1'b0);
    drv(1'b0, 2'b00, 16'h0, 1'b0, 2'b00, 16'h0);
    step("drop_pulse_end", Z, 1'b0);
    drv(1'b1, 2'b00, hf(5'd3, 5'd28), 1'b1, 2'b10, hf(5'd1, 5'd28));
    step("both_bad_req_first", ex(1,0,0,0,0,1,2'b00,16'h0), 1'b0);
    rpx = hf(5'd1, 5'd29);
    drv(1'b1, 2'b10, hf(5'd3, 5'd29), 1'b1, 2'b11, rpx);
    step("bad_req_good_rep", ex(0,1,0,0,1,0,2'b11,rpx), 1'b1);

    // Reset after three flits of a request message.
    drv(1'b1, 2'b01, hf(5'd3, 5'd30), 1'b0, 2'b00, 16'h0);
    step("lock_head", ex(1,0,1,0,0,0,2'b01,hf(5'd3, 5'd30)), 1'b1);
    drv(1'b1, 2'b10, hf(5'd3, 5'd31), 1'b0, 2'b00, 16'h0);
    step("lock_body1", ex(1,0,1,0,0,0,2'b10,hf(5'd3, 5'd31)), 1'b1);
    drv(1'b1, 2'b10, hf(5'd3, 5'd0), 1'b0, 2'b00, 16'h0);
    step("lock_body2", ex(1,0,1,0,0,0,2'b10,hf(5'd3, 5'd0)), 1'b1);
    rst = 1'b1;
    drv(1'b1, 2'b10, hf(5'd3, 5'd1), 1'b1, 2'b11, hf(5'd1, 5'd1));
    step("rst_in_lock", Z, 1'b1);
    rst = 1'b0;
    drv(1'b1, 2'b10, hf(5'd3, 5'd1), 1'b0, 2'b00, 16'h0);
    step("post_rst_drop", ex(1,0,0,0,0,1,2'b00,16'h0), 1'b0);
    drv(1'b1, 2'b11, rq, 1'b1, 2'b11, rp);
    step("post_rst_prio0", ex(1,0,1,0,0,0,2'b11,rq), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
